// File: rtl/player_hit_resolver.sv
// player_hit_resolver: per-edge wall overlap counter publishing a blocked-direction mask each frame (BOMB_COLLISION_EN adds bombs as obstacles)
module player_hit_resolver #(
  parameter int MIN_HIT_PIXELS = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       playerDR,
  input  logic [3:0] playerHitEdgeCode,
  input  logic       wallDR,
  input  logic       bombDR,
  output logic [3:0] blockedDirs,
  output logic       collisionPulse
);
  typedef enum logic [1:0] {IDLE, COLLECT, EVAL} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] snap [4];
  logic [CNT_W-1:0] cnt_nx [4];
  logic [3:0] eval_mask;
  logic obstacle;
  logic hit;
`ifdef BOMB_COLLISION_EN
  assign obstacle = wallDR | bombDR;
`else
  logic unused_bomb;
  assign unused_bomb = bombDR;
  assign obstacle = wallDR;
`endif
  assign hit = playerDR & obstacle;
  // saturating next count per edge and the threshold test on the closed frame
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_nx[k] = (hit && playerHitEdgeCode == 4'(k) && cnt[k] != '1) ? cnt[k] + CNT_W'(1) : cnt[k];
      eval_mask[k] = snap[k] >= CNT_W'(MIN_HIT_PIXELS);
    end
  end
  // frame FSM: accumulate, snapshot on frame boundary, publish one cycle later
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      blockedDirs <= '0;
      collisionPulse <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cnt[k] <= '0;
        snap[k] <= '0;
      end
    end else begin
      collisionPulse <= 1'b0;
      if (state == EVAL) begin
        blockedDirs <= eval_mask;
        collisionPulse <= |eval_mask;
      end
      if (state == IDLE) begin
        if (startOfFrame) state <= COLLECT;
      end else if (startOfFrame) begin
        for (int k = 0; k < 4; k++) begin
          snap[k] <= cnt_nx[k];
          cnt[k] <= '0;
        end
        state <= EVAL;
      end else begin
        for (int k = 0; k < 4; k++) cnt[k] <= cnt_nx[k];
        state <= COLLECT;
      end
    end
  end
endmodule

// File: tb/tb_player_hit_resolver.sv
// tb_player_hit_resolver: directed frames with hand-computed masks for the hit resolver
module tb_player_hit_resolver;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic playerDR = 1'b0;
  logic [3:0] playerHitEdgeCode = 4'd0;
  logic wallDR = 1'b0;
  logic bombDR = 1'b0;
  logic [3:0] blockedDirs, blocked_s;
  logic collisionPulse, pulse_s;
  int n_tests = 0;
  int n_fail = 0;
  logic [3:0] prev_m = 4'h0;
  logic [3:0] prev_s = 4'h0;
  player_hit_resolver dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playerDR(playerDR),
    .playerHitEdgeCode(playerHitEdgeCode), .wallDR(wallDR), .bombDR(bombDR),
    .blockedDirs(blockedDirs), .collisionPulse(collisionPulse)
  );
  player_hit_resolver #(.MIN_HIT_PIXELS(255)) dut_s (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playerDR(playerDR),
    .playerHitEdgeCode(playerHitEdgeCode), .wallDR(wallDR), .bombDR(bombDR),
    .blockedDirs(blocked_s), .collisionPulse(pulse_s)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic sof, input logic pdr, input logic [3:0] code, input logic wdr, input logic bdr);
    startOfFrame = sof;
    playerDR = pdr;
    playerHitEdgeCode = code;
    wallDR = wdr;
    bombDR = bdr;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, input logic pdr, input logic [3:0] code, input logic wdr, input logic bdr);
    for (int i = 0; i < n; i++) cyc(1'b0, pdr, code, wdr, bdr);
  endtask
  task automatic frame_end(input string tag, input logic pdr, input logic [3:0] code, input logic wdr,
                           input logic [3:0] exp_m, input logic [3:0] exp_s);
    cyc(1'b1, pdr, code, wdr, 1'b0);
    chk({tag, "_n1_pulse"}, {3'b0, collisionPulse}, 4'h0);
    chk({tag, "_n1_hold"}, blockedDirs, prev_m);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk({tag, "_mask"}, blockedDirs, exp_m);
    chk({tag, "_pulse"}, {3'b0, collisionPulse}, {3'b0, exp_m != 4'h0});
    chk({tag, "_mask_s"}, blocked_s, exp_s);
    chk({tag, "_pulse_s"}, {3'b0, pulse_s}, {3'b0, exp_s != 4'h0});
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk({tag, "_pulse_off"}, {3'b0, collisionPulse}, 4'h0);
    chk({tag, "_held"}, blockedDirs, exp_m);
    prev_m = exp_m;
    prev_s = exp_s;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mask", blockedDirs, 4'h0);
    chk("rst_pulse", {3'b0, collisionPulse}, 4'h0);
    resetN = 1'b1;
    run(6, 1'b1, 4'd2, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("idle_mask", blockedDirs, 4'h0);
    run(3, 1'b0, 4'd0, 1'b0, 1'b0);
    frame_end("pre1", 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
    frame_end("pre2", 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
    run(4, 1'b1, 4'd1, 1'b1, 1'b0);
    run(3, 1'b1, 4'd3, 1'b1, 1'b0);
    frame_end("left", 1'b0, 4'd0, 1'b0, 4'b0010, 4'h0);
    run(3, 1'b1, 4'd0, 1'b1, 1'b0);
    frame_end("bnd", 1'b1, 4'd0, 1'b1, 4'b0001, 4'h0);
    run(300, 1'b1, 4'd3, 1'b1, 1'b0);
    frame_end("sat300", 1'b0, 4'd0, 1'b0, 4'b1000, 4'b1000);
    run(254, 1'b1, 4'd3, 1'b1, 1'b0);
    frame_end("sat254", 1'b0, 4'd0, 1'b0, 4'b1000, 4'h0);
    run(10, 1'b1, 4'd7, 1'b1, 1'b0);
    frame_end("code7", 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
    run(5, 1'b0, 4'd0, 1'b1, 1'b0);
    frame_end("noplayer", 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
    run(5, 1'b1, 4'd0, 1'b0, 1'b1);
`ifdef BOMB_COLLISION_EN
    frame_end("bomb", 1'b0, 4'd0, 1'b0, 4'b0001, 4'h0);
`else
    frame_end("bomb", 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
`endif
    run(4, 1'b1, 4'd2, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'd1, 1'b1, 1'b0);
    chk("eval_sof_mask", blockedDirs, 4'b0100);
    chk("eval_sof_pulse", {3'b0, collisionPulse}, 4'h1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("eval_re_mask", blockedDirs, 4'h0);
    chk("eval_re_pulse", {3'b0, collisionPulse}, 4'h0);
    prev_m = 4'h0;
    run(4, 1'b1, 4'd2, 1'b1, 1'b0);
    frame_end("pre_rst", 1'b0, 4'd0, 1'b0, 4'b0100, 4'h0);
    run(5, 1'b1, 4'd2, 1'b1, 1'b0);
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_mask", blockedDirs, 4'h0);
    @(posedge clk);
    #3 resetN = 1'b1;
    prev_m = 4'h0;
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    frame_end("post_rst1", 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
    frame_end("post_rst2", 1'b0, 4'd0, 1'b0, 4'h0, 4'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
